sem_byte_serializer: RTL and testbench
======================================

# sem_byte_serializer

Producer stage that feeds the semaphore's single-bit memory slot. It accepts a WIDTH-bit word through a valid/ready handshake and writes it into the slot one bit per write strobe. Before each write it waits for the slot's empty flag, so no bit is overwritten before the consumer has taken it. It sits directly upstream of the semaphore/memory connector and drives its `sema_write_o` / `sema_data_o` inputs while observing its `sema_is_empty_i` output.

## Interface
Parameters:
- `WIDTH`, default 8: bits per accepted word; legal range is 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- `clk_s`  in  1  single clock; all logic is on the rising edge.
- `rst_s`  in  1  reset, synchronous and active-high.
- `byte_valid_i`  in  1  upstream word valid.
- `byte_data_i`  in  WIDTH  upstream word.
- `byte_ready_o`  out  1  block can accept a word (high only in IDLE).
- `sema_is_empty_i`  in  1  slot empty flag from the connector; 1 means the slot may be written.
- `sema_write_o`  out  1  one-cycle write strobe to the slot.
- `sema_data_o`  out  1  bit being written; valid while `sema_write_o`=1.
- `bits_left_o`  out  $clog2(WIDTH+1)  bits of the current word not yet written.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse after the last bit's GUARD cycle.

## Operation
- States:
  - IDLE: `byte_ready_o`=1.
  - WAIT_SLOT: wait for the slot to empty.
  - WRITE: `sema_write_o`=1.
  - GUARD: one cycle in which `sema_is_empty_i` is ignored, covering the connector's one-cycle flag update.
- IDLE, `byte_valid_i`=1: load the shift register with `byte_data_i`, set `bits_left_o`=WIDTH, go to WAIT_SLOT.
- IDLE, `byte_valid_i`=0: stay in IDLE.
- WAIT_SLOT, `sema_is_empty_i`=1: go to WRITE. If `sema_is_empty_i`=0, stay in WAIT_SLOT with no timeout.
- WRITE:
  - `sema_data_o` = the current head bit: shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Shift the register toward the head.
  - Decrement `bits_left_o` by 1.
  - Go to GUARD.
- GUARD:
  - If `bits_left_o`=0: go to IDLE and assert `done_o` for the first IDLE cycle.
  - Otherwise: go to WAIT_SLOT.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- `sema_data_o` holds the last written bit outside WRITE.
- Upstream changes to `byte_data_i` while busy have no effect, since `byte_ready_o`=0.
- Reset values: state=IDLE, `byte_ready_o`=0 during the reset cycle and 1 afterwards, `sema_write_o`=0, `sema_data_o`=0, `bits_left_o`=0, `busy_o`=0, `done_o`=0, shift register=0.

## Timing
- The word is accepted in cycle A, the edge where `byte_valid_i`=1 and `byte_ready_o`=1. WAIT_SLOT starts in A+1.
- The minimum bit period is 3 cycles (WAIT_SLOT, WRITE, GUARD).
- With the slot always empty, bit k is written in cycle A+2+3k, for k=0..WIDTH-1.
- For WIDTH=8 with the slot always empty:
  - Last write is in A+23.
  - GUARD is in A+24.
  - `done_o` and `byte_ready_o` are both 1 in A+25.
  - The next word can be accepted at the end of A+25.
- Each cycle of `sema_is_empty_i`=0 in WAIT_SLOT adds exactly one cycle to that bit.
- `sema_write_o` is never high on two consecutive cycles. Writes are always at least 3 cycles apart.
- Reset in any cycle, including WRITE, returns every output to its reset value on the next cycle. The partial word is discarded with no `done_o`. A strobe already driven in the cycle that samples `rst_s` is not suppressed.
- `rst_s` and `byte_valid_i` high in the same cycle: reset wins and the word is not accepted.
- `done_o` and a new acceptance may occur in the same cycle (A+25 above).

## Test plan
- Reset, then idle: hold `rst_s`=1 for 2 cycles, then release. Required: every output at its reset value, and `byte_ready_o`=1 from the first cycle after release.
- Single word, MSB_FIRST=1, WIDTH=8: data 0xA5 with the slot always empty. Required: writes at A+2, A+5, …, A+23 carrying bits 1,0,1,0,0,1,0,1; `bits_left_o` steps 8→0; `done_o` pulses at A+25.
- MSB_FIRST=0: data 0x01. Required: first written bit is 1, the remaining seven are 0.
- Back-pressure: data 0xFF with `sema_is_empty_i` held 0 for 5 cycles before bit 3. Required: bit 3's write is delayed exactly 5 cycles, no extra or duplicate strobes occur, and exactly 8 writes are issued in total.
- Back-to-back words: 0x3C then 0xC3, with valid held. Required: the second word is accepted at A+25, there are 16 writes, and no strobes are adjacent.
- Reset mid-word: assert `rst_s` after 3 writes of 0x5A. Required: outputs return to their reset values next cycle, no `done_o`, and the next word is serialized from its bit 7 with `bits_left_o`=8.

Source files
------------

// File: rtl/sem_byte_serializer.sv
// Serializes a WIDTH-bit word into the semaphore's single-bit slot, one bit per
// write strobe, waiting for the slot to drain before every write.
module sem_byte_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk_s,
  input  logic                       rst_s,
  input  logic                       byte_valid_i,
  input  logic [WIDTH-1:0]           byte_data_i,
  output logic                       byte_ready_o,
  input  logic                       sema_is_empty_i,
  output logic                       sema_write_o,
  output logic                       sema_data_o,
  output logic [$clog2(WIDTH+1)-1:0] bits_left_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    WRITE,
    GUARD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CW-1:0]    bitsLeft_q, bitsLeft_d;
  logic             dataBit_q, dataBit_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             headBit;

  assign headBit = (MSB_FIRST != 0) ? shiftReg_q[WIDTH-1] : shiftReg_q[0];

  // Ready is registered so it stays low for the cycle that follows a reset edge.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      bitsLeft_q <= '0;
      dataBit_q  <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      bitsLeft_q <= bitsLeft_d;
      dataBit_q  <= dataBit_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitsLeft_d = bitsLeft_q;
    dataBit_d  = dataBit_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && byte_valid_i) begin
          shiftReg_d = byte_data_i;
          bitsLeft_d = CW'(WIDTH);
          state_d    = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        // The head bit is captured on entry to WRITE and then held as the last written bit.
        if (sema_is_empty_i) begin
          dataBit_d = headBit;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (MSB_FIRST != 0) begin
          shiftReg_d = {shiftReg_q[WIDTH-2:0], 1'b0};
        end else begin
          shiftReg_d = {1'b0, shiftReg_q[WIDTH-1:1]};
        end
        bitsLeft_d = bitsLeft_q - CW'(1);
        state_d    = GUARD;
      end
      GUARD: begin
        if (bitsLeft_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_SLOT;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  assign byte_ready_o = ready_q;
  assign sema_write_o = (state_q == WRITE);
  assign sema_data_o  = dataBit_q;
  assign bits_left_o  = bitsLeft_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_sem_byte_serializer.sv
// Drives an MSB-first and an LSB-first serializer with the same stimulus and
// checks both against a timeline computed from the bit-period rules.
module tb_sem_byte_serializer;

  logic       clk_s = 1'b0;
  logic       rstS;
  logic       byteValid;
  logic [7:0] byteData;
  logic       semaEmpty;

  logic       ready0, write0, sdat0, busy0, done0;
  logic       ready1, write1, sdat1, busy1, done1;
  logic [3:0] bits0, bits1;

  int checks = 0;
  int errors = 0;
  int writeCount = 0;
  int adjacentCount = 0;
  logic prevW0 = 1'b0;
  logic prevW1 = 1'b0;

  logic lastMsb;
  logic lastLsb;

  always #5 clk_s = ~clk_s;

  sem_byte_serializer #(.WIDTH(8), .MSB_FIRST(1)) dutMsb (
    .clk_s(clk_s), .rst_s(rstS), .byte_valid_i(byteValid), .byte_data_i(byteData),
    .byte_ready_o(ready0), .sema_is_empty_i(semaEmpty), .sema_write_o(write0),
    .sema_data_o(sdat0), .bits_left_o(bits0), .busy_o(busy0), .done_o(done0)
  );

  sem_byte_serializer #(.WIDTH(8), .MSB_FIRST(0)) dutLsb (
    .clk_s(clk_s), .rst_s(rstS), .byte_valid_i(byteValid), .byte_data_i(byteData),
    .byte_ready_o(ready1), .sema_is_empty_i(semaEmpty), .sema_write_o(write1),
    .sema_data_o(sdat1), .bits_left_o(bits1), .busy_o(busy1), .done_o(done1)
  );

  // Strobe monitor: total writes of the MSB-first unit and any back-to-back strobes.
  always @(negedge clk_s) begin
    if (write0 === 1'b1) writeCount <= writeCount + 1;
    if ((write0 === 1'b1 && prevW0) || (write1 === 1'b1 && prevW1)) adjacentCount <= adjacentCount + 1;
    prevW0 <= (write0 === 1'b1);
    prevW1 <= (write1 === 1'b1);
  end

  task automatic step();
    @(posedge clk_s);
    @(negedge clk_s);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic eW, input logic eD0, input logic eD1,
                            input logic [3:0] eBits, input logic eBusy, input logic eReady,
                            input logic eDone);
    checkOutput({tag, "/write_msb"}, {31'b0, write0}, {31'b0, eW});
    checkOutput({tag, "/write_lsb"}, {31'b0, write1}, {31'b0, eW});
    checkOutput({tag, "/data_msb"},  {31'b0, sdat0},  {31'b0, eD0});
    checkOutput({tag, "/data_lsb"},  {31'b0, sdat1},  {31'b0, eD1});
    checkOutput({tag, "/bits_msb"},  {28'b0, bits0},  {28'b0, eBits});
    checkOutput({tag, "/bits_lsb"},  {28'b0, bits1},  {28'b0, eBits});
    checkOutput({tag, "/busy"},      {30'b0, busy0, busy1},   {30'b0, eBusy, eBusy});
    checkOutput({tag, "/ready"},     {30'b0, ready0, ready1}, {30'b0, eReady, eReady});
    checkOutput({tag, "/done"},      {30'b0, done0, done1},   {30'b0, eDone, eDone});
  endtask

  // Offers a word in the current (IDLE) cycle and follows it to completion.
  // Bit k is written at offset 2+3k plus all stall cycles up to and including bit k.
  task automatic applyStimulus(input string tag, input logic [7:0] data, input int stalls[8],
                               input bit chain, input int abortAt);
    int off[8];
    int waitStart[8];
    int acc;
    int endT;
    int written;
    int bitIdx;
    logic expW;
    logic emptyVal;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      acc += stalls[k];
      off[k] = 2 + 3 * k + acc;
      waitStart[k] = off[k] - 1 - stalls[k];
    end
    endT = off[7] + 2;
    checkOutput({tag, "/ready_at_accept"}, {30'b0, ready0, ready1}, 32'd3);
    byteValid = 1'b1;
    byteData  = data;
    semaEmpty = 1'($urandom_range(0, 1));
    for (int t = 1; t <= endT; t++) begin
      step();
      expW = 1'b0;
      written = 0;
      bitIdx = 0;
      for (int k = 0; k < 8; k++) begin
        if (off[k] < t) written++;
        if (off[k] == t) begin
          expW = 1'b1;
          bitIdx = k;
        end
      end
      if (expW) begin
        lastMsb = data[7 - bitIdx];
        lastLsb = data[bitIdx];
      end
      checkCycle(tag, expW, lastMsb, lastLsb, 4'(8 - written), (t < endT), (t == endT), (t == endT));
      if (t == abortAt) begin
        rstS = 1'b1;
        byteValid = 1'b0;
        return;
      end
      if (t == endT) begin
        if (!chain) byteValid = 1'b0;
      end else begin
        byteValid = 1'($urandom_range(0, 1));
        byteData  = 8'($urandom);
      end
      emptyVal = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        if (t >= waitStart[k] && t < off[k] - 1) emptyVal = 1'b0;
        if (t == off[k] - 1) emptyVal = 1'b1;
      end
      semaEmpty = emptyVal;
    end
  endtask

  task automatic idleCycles(input string tag, input int n);
    byteValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      semaEmpty = 1'($urandom_range(0, 1));
      step();
      checkCycle(tag, 1'b0, lastMsb, lastLsb, 4'd0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    int st[8];
    int base;
    bit chainNext;

    // Reset held for two cycles with a competing valid word that must be ignored.
    rstS = 1'b1;
    byteValid = 1'b1;
    byteData = 8'hE7;
    semaEmpty = 1'b1;
    lastMsb = 1'b0;
    lastLsb = 1'b0;
    step();
    checkCycle("reset1", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkCycle("reset2", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rstS = 1'b0;
    byteValid = 1'b0;
    step();
    checkCycle("post_reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idleCycles("idle", 2);

    st = '{default: 0};
    base = writeCount;
    applyStimulus("word_a5", 8'hA5, st, 1'b0, -1);
    idleCycles("after_a5", 2);
    checkOutput("a5/write_count", writeCount - base, 32'd8);

    applyStimulus("word_01", 8'h01, st, 1'b0, -1);
    idleCycles("after_01", 1);

    st[3] = 5;
    base = writeCount;
    applyStimulus("word_ff_stall", 8'hFF, st, 1'b0, -1);
    idleCycles("after_ff", 2);
    checkOutput("ff/write_count", writeCount - base, 32'd8);

    st = '{default: 0};
    base = writeCount;
    applyStimulus("word_3c", 8'h3C, st, 1'b1, -1);
    applyStimulus("word_c3", 8'hC3, st, 1'b0, -1);
    idleCycles("after_c3", 2);
    checkOutput("b2b/write_count", writeCount - base, 32'd16);

    // Reset asserted in the third write cycle of 0x5A; that strobe is still visible.
    applyStimulus("word_5a_abort", 8'h5A, st, 1'b0, 8);
    step();
    lastMsb = 1'b0;
    lastLsb = 1'b0;
    checkCycle("mid_reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rstS = 1'b0;
    step();
    checkCycle("mid_reset_release", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus("word_after_reset", 8'($urandom), st, 1'b0, -1);
    idleCycles("after_reset_word", 1);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) st[k] = int'($urandom_range(0, 3));
      chainNext = (r < 4) ? bit'($urandom_range(0, 1)) : 1'b0;
      applyStimulus("random_word", 8'($urandom), st, chainNext, -1);
      if (!chainNext) idleCycles("random_idle", 1);
    end

    idleCycles("final_idle", 2);
    checkOutput("no_adjacent_strobes", adjacentCount, 32'd0);

    $display("[TB] stimulus complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
